// File: rtl/alu_mux_arbiter.sv
// Round-robin arbiter that owns the select of a 4-bit 2:1 mux shared by two
// burst requesters, and registers the selected beat with a valid flag and source tag.
module alu_mux_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] len0,
    input  logic [1:0] len1,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       sel,
    output logic [3:0] out,
    output logic       out_valid,
    output logic       out_src,
    output logic       busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] beats_q, beats_d;
    logic       sel_q, sel_d;
    logic [3:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       out_src_q, out_src_d;

    logic       arbValid;
    logic       arbIdx;
    logic       burstDone;

    // On a tie the requester that did not win last time gets the path.
    assign arbValid = req0 | req1;
    assign arbIdx   = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        beats_d     = beats_q;
        sel_d       = sel_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        out_src_d   = out_src_q;
        burstDone   = 1'b0;

        case (state_q)
            IDLE: begin
                burstDone = 1'b1;
            end
            GRANT0: begin
                out_d       = d0;
                out_valid_d = 1'b1;
                out_src_d   = 1'b0;
                if (beats_q != 2'd0) beats_d = beats_q - 2'd1;
                else                 burstDone = 1'b1;
            end
            GRANT1: begin
                out_d       = d1;
                out_valid_d = 1'b1;
                out_src_d   = 1'b1;
                if (beats_q != 2'd0) beats_d = beats_q - 2'd1;
                else                 burstDone = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Re-arbitrating on the last beat lets back-to-back bursts run without a bubble.
        if (burstDone) begin
            if (arbValid) begin
                state_d = arbIdx ? GRANT1 : GRANT0;
                beats_d = arbIdx ? len1 : len0;
                last_d  = arbIdx;
                sel_d   = arbIdx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            beats_q     <= 2'd0;
            sel_q       <= 1'b0;
            out_q       <= 4'h0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            beats_q     <= beats_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
        end
    end

    assign gnt0      = (state_q == GRANT0);
    assign gnt1      = (state_q == GRANT1);
    assign busy      = (state_q != IDLE);
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// Randomised scoreboard bench for alu_mux_arbiter: a burst-level reference model
// predicts grants and queues expected beats, a monitor pops them as out_valid appears.
module tb_alu_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [1:0] len0, len1;
    logic [3:0] d0, d1;
    logic       gnt0, gnt1, sel, out_valid, out_src, busy;
    logic [3:0] out;

    int tests = 0;
    int fails = 0;

    // Reference model: current owner (-1 when idle), beats still owed, last winner.
    int   owner;
    int   remaining;
    int   lastWinner;
    logic selModel;
    logic resetEdge;
    logic [4:0] expQ[$];

    alu_mux_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .len0      (len0),
        .len1      (len1),
        .d0        (d0),
        .d1        (d1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .out_src   (out_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        int pick;
        resetEdge = rst;
        if (rst) begin
            owner      = -1;
            remaining  = 0;
            lastWinner = 1;
            selModel   = 1'b0;
            return;
        end
        if (owner >= 0) begin
            expQ.push_back({owner[0], (owner == 0) ? d0 : d1});
            remaining--;
            if (remaining > 0) return;
        end
        if (req0 && req1)  pick = 1 - lastWinner;
        else if (req0)     pick = 0;
        else if (req1)     pick = 1;
        else               pick = -1;
        owner = pick;
        if (pick >= 0) begin
            remaining  = ((pick == 0) ? int'(len0) : int'(len1)) + 1;
            lastWinner = pick;
            selModel   = pick[0];
        end
    endtask

    task automatic checkOutput();
        check("gnt0", gnt0, owner == 0);
        check("gnt1", gnt1, owner == 1);
        check("busy", busy, owner >= 0);
        check("sel", sel, selModel);
        if (resetEdge) begin
            check("rst_out", out, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_src", out_src, 0);
        end
    endtask

    task automatic applyStimulus();
        d0 = 4'($urandom);
        d1 = 4'($urandom);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    // Monitor: every presented beat must match the oldest predicted beat.
    always @(negedge clk) begin
        if (out_valid) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_beat at %0t: got out=%0d src=%0d, expected none", $time, out, out_src);
            end else begin
                logic [4:0] e;
                e = expQ.pop_front();
                check("beat_data", out, e[3:0]);
                check("beat_src", out_src, e[4]);
            end
        end
    end

    initial begin
        owner = -1; remaining = 0; lastWinner = 1; selModel = 1'b0; resetEdge = 1'b0;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0; d0 = 4'h0; d1 = 4'h0;
        @(negedge clk);

        // Reset held with both requesting, then tie goes to requester 0.
        repeat (2) applyStimulus();
        rst = 1'b0;
        applyStimulus();
        check("first_tie_gnt0", gnt0, 1);

        // Contention with short and two-beat bursts.
        len0 = 2'd0; len1 = 2'd1;
        repeat (12) applyStimulus();
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) applyStimulus();

        // Single three-beat burst from requester 0.
        req0 = 1'b1; len0 = 2'd2;
        applyStimulus();
        req0 = 1'b0;
        repeat (5) applyStimulus();

        // Request dropped mid-burst.
        req1 = 1'b1; len1 = 2'd3;
        repeat (2) applyStimulus();
        req1 = 1'b0; len1 = 2'd0;
        repeat (5) applyStimulus();

        // Reset on the third cycle of a four-beat grant.
        req1 = 1'b1; len1 = 2'd3;
        repeat (3) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        check("gnt1_after_reset", gnt1, 1);
        req1 = 1'b0;
        repeat (5) applyStimulus();

        // Single requester repeating two-beat bursts.
        req0 = 1'b1; len0 = 2'd1;
        repeat (10) applyStimulus();
        req0 = 1'b0;
        repeat (3) applyStimulus();

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            len0 = 2'($urandom);
            len1 = 2'($urandom);
            rst  = ($urandom_range(0, 49) == 0);
            applyStimulus();
        end

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (6) applyStimulus();
        check("scoreboard_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
